// File: rtl/window_shift_ctrl.sv
// Sliding-window sequencer: feeds a SIZE-deep shift register from a row-framed
// pixel stream and presents each full same-row window with valid/ready backpressure.
module window_shift_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int SIZE       = 8,
  parameter int ROW_WIDTH  = 640,
  parameter int COL_W      = $clog2(ROW_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic                  sr_shift_en,
  output logic [DATA_WIDTH-1:0] sr_in_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [COL_W-1:0]      m_col,
  output logic                  m_last,
  output logic                  err_row_len
);

  localparam int FILL_W = $clog2(SIZE + 1);

  typedef enum logic {FILL, STREAM} state_t;

  state_t            state;
  logic [FILL_W-1:0] fill_cnt;
  logic [COL_W-1:0]  col;
  logic [FILL_W:0]   fill_inc;
  logic              acc;
  logic              row_overrun;
  logic              row_end;

  // A resident window may only be replaced in the cycle it is consumed.
  assign s_ready     = rst_n && (!m_valid || m_ready);
  assign acc         = s_valid && s_ready;
  assign sr_shift_en = acc;
  assign sr_in_data  = s_data;

  assign row_overrun = (col == COL_W'(ROW_WIDTH - 1));
  assign row_end     = s_last || row_overrun;
  assign fill_inc    = {1'b0, fill_cnt} + (FILL_W + 1)'(1);

  // STREAM means SIZE-1 pixels of this row are already resident, so the
  // next accepted pixel completes a window.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= FILL;
      fill_cnt    <= '0;
      col         <= '0;
      m_valid     <= 1'b0;
      m_col       <= '0;
      m_last      <= 1'b0;
      err_row_len <= 1'b0;
    end else if (acc) begin
      m_valid <= (state == STREAM);
      m_col   <= col;
      m_last  <= row_end;
      if (row_overrun && !s_last)
        err_row_len <= 1'b1;
      if (row_end) begin
        state    <= FILL;
        fill_cnt <= '0;
        col      <= '0;
      end else begin
        col <= col + COL_W'(1);
        if (fill_inc <= (FILL_W + 1)'(SIZE))
          fill_cnt <= fill_inc[FILL_W-1:0];
        if (fill_inc == (FILL_W + 1)'(SIZE - 1))
          state <= STREAM;
      end
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_window_shift_ctrl.sv
// Directed and randomized checks of window_shift_ctrl against a small cycle
// model plus an emulated shift register driven by the DUT's sr_* outputs.
module tb_window_shift_ctrl;

  localparam int DW = 8;
  localparam int SZ = 4;
  localparam int RW = 16;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_last = 1'b0;
  logic          m_ready = 1'b0;
  logic          s_ready, sr_shift_en, m_valid, m_last, err_row_len;
  logic [DW-1:0] sr_in_data;
  logic [CW-1:0] m_col;

  int checks = 0;
  int failures = 0;

  logic          mv = 1'b0, mlast = 1'b0, merr = 1'b0;
  int            mcol = 0, col = 0, fill = 0;
  logic [DW-1:0] hist [SZ];
  logic [DW-1:0] sr [SZ];

  window_shift_ctrl #(.DATA_WIDTH(DW), .SIZE(SZ), .ROW_WIDTH(RW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .sr_shift_en(sr_shift_en), .sr_in_data(sr_in_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_col(m_col), .m_last(m_last),
    .err_row_len(err_row_len)
  );

  always #5 clk = ~clk;

  // Stand-in for the shift register the controller drives.
  always @(posedge clk) begin
    if (sr_shift_en) begin
      for (int i = SZ - 1; i > 0; i--) sr[i] <= sr[i-1];
      sr[0] <= sr_in_data;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check combinational outputs, step model at posedge.
  task automatic applyStimulus(input logic rst, input logic v, input logic [DW-1:0] d,
                               input logic l, input logic r);
    logic accx, rowend;
    @(negedge clk);
    rst_n = rst; s_valid = v; s_data = d; s_last = l; m_ready = r;
    #1;
    accx = rst && v && (!mv || r);
    checkOutput("s_ready", s_ready, rst && (!mv || r));
    checkOutput("sr_shift_en", sr_shift_en, accx);
    if (accx) checkOutput("sr_in_data", sr_in_data, d);
    @(posedge clk);
    if (!rst) begin
      mv = 1'b0; mcol = 0; mlast = 1'b0; merr = 1'b0; col = 0; fill = 0;
    end else if (accx) begin
      rowend = l || (col == RW - 1);
      if (col == RW - 1 && !l) merr = 1'b1;
      for (int i = SZ - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = d;
      mv    = (fill + 1 >= SZ);
      mcol  = col;
      mlast = rowend;
      if (rowend) begin
        col = 0; fill = 0;
      end else begin
        col++;
        fill = (fill + 1 > SZ) ? SZ : fill + 1;
      end
    end else if (r) begin
      mv = 1'b0;
    end
    #1;
    checkOutput("m_valid", m_valid, mv);
    checkOutput("err_row_len", err_row_len, merr);
    if (mv) begin
      checkOutput("m_col", m_col, mcol);
      checkOutput("m_last", m_last, mlast);
      for (int i = 0; i < SZ; i++) checkOutput($sformatf("win[%0d]", i), sr[i], hist[i]);
    end
  endtask

  initial begin
    int windows;

    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 8'h55, 1'b0, 1'b1);
    checkOutput("rst_m_valid", m_valid, 1'b0);
    checkOutput("rst_err", err_row_len, 1'b0);

    // Full 16-pixel row with the consumer always ready.
    windows = 0;
    for (int p = 1; p <= 16; p++) begin
      applyStimulus(1'b1, 1'b1, DW'(p), p == 16, 1'b1);
      if (p == 3) checkOutput("t1_no_early_win", m_valid, 1'b0);
      if (p == 4) begin
        checkOutput("t1_first_win", m_valid, 1'b1);
        checkOutput("t1_first_col", m_col, 3);
      end
      if (m_valid) windows++;
    end
    checkOutput("t1_win_count", windows, 13);
    checkOutput("t1_last_col", m_col, 15);
    checkOutput("t1_last_flag", m_last, 1'b1);
    checkOutput("t1_newest", sr[0], 16);
    checkOutput("t1_oldest", sr[3], 13);

    // Backpressure after the first window of a row.
    for (int p = 1; p <= 4; p++) applyStimulus(1'b1, 1'b1, DW'(8'h20 + p), 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 1'b1, 8'h25, 1'b0, 1'b0);
      checkOutput("t2_stall_ready", s_ready, 1'b0);
      checkOutput("t2_stall_shift", sr_shift_en, 1'b0);
      checkOutput("t2_stall_col", m_col, 3);
      checkOutput("t2_stall_valid", m_valid, 1'b1);
    end
    applyStimulus(1'b1, 1'b1, 8'h25, 1'b0, 1'b1);
    checkOutput("t2_resume_col", m_col, 4);
    checkOutput("t2_resume_pix", sr[0], 8'h25);
    applyStimulus(1'b1, 1'b1, 8'h26, 1'b1, 1'b1);
    checkOutput("t2_end_col", m_col, 5);
    checkOutput("t2_end_last", m_last, 1'b1);

    // Short row never produces a window; next row needs four fresh pixels.
    for (int p = 1; p <= 3; p++) begin
      applyStimulus(1'b1, 1'b1, DW'(8'h30 + p), p == 3, 1'b1);
      checkOutput("t3_short_row", m_valid, 1'b0);
    end
    for (int p = 1; p <= 4; p++) begin
      applyStimulus(1'b1, 1'b1, DW'(8'h40 + p), p == 4, 1'b1);
      checkOutput("t3_row2_valid", m_valid, p == 4);
    end
    checkOutput("t3_row2_col", m_col, 3);
    checkOutput("t3_row2_oldest", sr[3], 8'h41);

    // Row overrun without s_last.
    for (int p = 1; p <= 18; p++) begin
      applyStimulus(1'b1, 1'b1, DW'(8'h50 + p), 1'b0, 1'b1);
      if (p == 15) checkOutput("t4_err_early", err_row_len, 1'b0);
      if (p == 16) begin
        checkOutput("t4_err_set", err_row_len, 1'b1);
        checkOutput("t4_overrun_last", m_last, 1'b1);
        checkOutput("t4_overrun_col", m_col, 15);
      end
      if (p == 17) checkOutput("t4_refill", m_valid, 1'b0);
    end
    checkOutput("t4_err_sticky", err_row_len, 1'b1);

    // Mid-row reset discards the window and the error flag.
    for (int p = 1; p <= 6; p++) applyStimulus(1'b1, 1'b1, DW'(8'h70 + p), 1'b0, 1'b1);
    checkOutput("t5_pre_valid", m_valid, 1'b1);
    applyStimulus(1'b0, 1'b1, 8'h77, 1'b0, 1'b1);
    checkOutput("t5_rst_valid", m_valid, 1'b0);
    checkOutput("t5_rst_err", err_row_len, 1'b0);
    for (int p = 1; p <= 4; p++) begin
      applyStimulus(1'b1, 1'b1, DW'(8'h80 + p), 1'b0, 1'b1);
      checkOutput("t5_refill", m_valid, p == 4);
    end
    checkOutput("t5_refill_col", m_col, 3);

    // Randomized traffic against the model and emulated shift register.
    for (int c = 0; c < 10000; c++)
      applyStimulus(1'b1, 1'($urandom_range(0, 1)), DW'($urandom),
                    $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
